// File: rtl/down_timer_pkg.sv
// Shared constants and types for the down_timer peripheral: register map,
// CTRL field positions, mode encoding and FSM state encoding.
package down_timer_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;
  localparam logic [1:0] ADDR_RSVD   = 2'd3;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IM_BIT   = 3;

  // Only 01 reloads; 00 and 1x both behave as one-shot.
  localparam logic [1:0] MODE_AUTO = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_e;

  function automatic logic is_auto(input logic [1:0] mode);
    return (mode == MODE_AUTO);
  endfunction

endpackage

// File: rtl/down_timer_if.sv
// Peripheral-bus bundle for down_timer: register write/read port plus interrupt.
interface down_timer_if #(
  parameter int WIDTH = 32
) ();

  logic             we;
  logic [1:0]       addr;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rdata;
  logic             irq;

  modport master (
    output we,
    output addr,
    output wdata,
    input  rdata,
    input  irq
  );

  modport slave (
    input  we,
    input  addr,
    input  wdata,
    output rdata,
    output irq
  );

endinterface

// File: rtl/down_timer.sv
// Programmable down-counting timer with one-shot / auto-reload modes.
// Interrupt logic (IM bit, pending flag, irq) is present only when DOWN_TIMER_IRQ_EN is defined.
module down_timer
  import down_timer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  down_timer_if.slave  bus
);

  state_e           state_q, state_d;
  logic             en_q, en_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] preset_q, preset_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             irq_q, irq_d;
  logic             im_s;
  logic             ctrl_wr_s;
  logic             preset_wr_s;
  logic [WIDTH-1:0] ctrl_rd_s;

`ifdef DOWN_TIMER_IRQ_EN
  logic             im_q, im_d;
  logic             pending_q, pending_d;
  logic             pend_set_s;
  logic             pend_clr_s;
  assign im_s = im_q;
`else
  assign im_s = 1'b0;
`endif

  assign ctrl_wr_s   = bus.we && (bus.addr == ADDR_CTRL);
  assign preset_wr_s = bus.we && (bus.addr == ADDR_PRESET);

  // FSM next state, counter datapath and register writes
  always_comb begin
    state_d  = state_q;
    en_d     = en_q;
    mode_d   = mode_q;
    preset_d = preset_q;
    count_d  = count_q;

    case (state_q)
      ST_IDLE: begin
        if (en_q) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!en_q) begin
          state_d = ST_IDLE;
        end else if (count_q == '0) begin
          // One-shot drops EN on the edge that enters INT, so a CTRL write
          // landing on that same edge can override it below.
          state_d = ST_INT;
          if (!is_auto(mode_q)) begin
            en_d = 1'b0;
          end else begin
            en_d = en_q;
          end
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
      ST_INT: begin
        if (is_auto(mode_q)) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (ctrl_wr_s) begin
      en_d   = bus.wdata[CTRL_EN_BIT];
      mode_d = bus.wdata[CTRL_MODE_MSB:CTRL_MODE_LSB];
    end else begin
      mode_d = mode_q;
    end

    if (preset_wr_s) begin
      preset_d = bus.wdata;
    end else begin
      preset_d = preset_q;
    end
  end

`ifdef DOWN_TIMER_IRQ_EN
  // Interrupt mask, sticky one-shot pending flag and irq next value
  always_comb begin
    pend_set_s = (state_q == ST_CNT) && en_q && (count_q == '0) && !is_auto(mode_q);
    pend_clr_s = ctrl_wr_s || preset_wr_s;

    if (ctrl_wr_s) begin
      im_d = bus.wdata[CTRL_IM_BIT];
    end else begin
      im_d = im_q;
    end

    if (pend_set_s) begin
      pending_d = 1'b1;
    end else if (pend_clr_s) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end

    irq_d = (pending_d && im_d) ||
            ((state_q == ST_INT) && is_auto(mode_q) && im_q);
  end
`else
  // Interrupt support compiled out
  always_comb begin
    irq_d = 1'b0;
  end
`endif

  // State and register update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      en_q      <= 1'b0;
      mode_q    <= 2'b00;
      preset_q  <= '0;
      count_q   <= '0;
      irq_q     <= 1'b0;
`ifdef DOWN_TIMER_IRQ_EN
      im_q      <= 1'b0;
      pending_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      en_q      <= en_d;
      mode_q    <= mode_d;
      preset_q  <= preset_d;
      count_q   <= count_d;
      irq_q     <= irq_d;
`ifdef DOWN_TIMER_IRQ_EN
      im_q      <= im_d;
      pending_q <= pending_d;
`endif
    end
  end

  // CTRL readback image; unimplemented bits read 0
  always_comb begin
    ctrl_rd_s                              = '0;
    ctrl_rd_s[CTRL_EN_BIT]                 = en_q;
    ctrl_rd_s[CTRL_MODE_MSB:CTRL_MODE_LSB] = mode_q;
    ctrl_rd_s[CTRL_IM_BIT]                 = im_s;
  end

  // Combinational register read mux
  always_comb begin
    case (bus.addr)
      ADDR_CTRL:   bus.rdata = ctrl_rd_s;
      ADDR_PRESET: bus.rdata = preset_q;
      ADDR_COUNT:  bus.rdata = count_q;
      ADDR_RSVD:   bus.rdata = '0;
      default:     bus.rdata = '0;
    endcase
  end

  assign bus.irq = irq_q;

endmodule

// File: tb/tb_down_timer.sv
// Directed self-checking bench for down_timer; irq expectations follow DOWN_TIMER_IRQ_EN.
module tb_down_timer;

`ifdef DOWN_TIMER_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_PRESET = 2'd1;
  localparam logic [1:0] A_COUNT  = 2'd2;
  localparam logic [1:0] A_RSVD   = 2'd3;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  down_timer_if #(.WIDTH(32)) bus_if ();

  down_timer #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus_if.we    = 1'b1;
    bus_if.addr  = a;
    bus_if.wdata = d;
    @(posedge clk);
    #1;
    bus_if.we    = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    bus_if.addr = a;
    #1;
    v = bus_if.rdata;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus_if.we    = 1'($urandom);
      bus_if.addr  = 2'($urandom);
      bus_if.wdata = $urandom;
      step();
    end
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), v);
      checks++;
      if (v !== 32'd0) begin
        errors++;
        $display("FAIL reset_read addr=%0d got=%h exp=0", a, v);
      end
    end
    checks++;
    if (bus_if.irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_irq got=%b exp=0", bus_if.irq);
    end
    bus_if.we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    // Asynchronous reset in the middle of a count
    wr(A_PRESET, 32'd10);
    wr(A_CTRL, 32'd1);
    for (int k = 1; k <= 7; k++) step();
    rd(A_COUNT, v);
    checks++;
    if (v !== 32'd5) begin
      errors++;
      $display("FAIL midcount_pre got=%0d exp=5", v);
    end
    rst_n = 1'b0;
    rd(A_COUNT, v);
    checks++;
    if (v !== 32'd0) begin
      errors++;
      $display("FAIL async_reset_count got=%0d exp=0", v);
    end
    rd(A_CTRL, v);
    checks++;
    if (v !== 32'd0) begin
      errors++;
      $display("FAIL async_reset_ctrl got=%h exp=0", v);
    end
    rd(A_PRESET, v);
    checks++;
    if (v !== 32'd0) begin
      errors++;
      $display("FAIL async_reset_preset got=%h exp=0", v);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();
    rd(A_COUNT, v);
    checks++;
    if (v !== 32'd0) begin
      errors++;
      $display("FAIL post_reset_idle_count got=%0d exp=0", v);
    end
  endtask

  task automatic test_regs();
    logic [31:0] v;
    wr(A_PRESET, 32'hDEADBEEF);
    rd(A_PRESET, v);
    checks++;
    if (v !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL preset_readback got=%h exp=deadbeef", v);
    end
    wr(A_COUNT, 32'd5);
    rd(A_COUNT, v);
    checks++;
    if (v !== 32'd0) begin
      errors++;
      $display("FAIL count_write_ignored got=%h exp=0", v);
    end
    wr(A_RSVD, 32'hFFFFFFFF);
    rd(A_RSVD, v);
    checks++;
    if (v !== 32'd0) begin
      errors++;
      $display("FAIL rsvd_read got=%h exp=0", v);
    end
    wr(A_CTRL, 32'hFFFFFFFE);
    rd(A_CTRL, v);
    checks++;
    if (v !== (IRQ_ON ? 32'hE : 32'h6)) begin
      errors++;
      $display("FAIL ctrl_upper_bits got=%h exp=%h", v, (IRQ_ON ? 32'hE : 32'h6));
    end
    wr(A_CTRL, 32'd0);
  endtask

  task automatic test_oneshot();
    logic [31:0] v;
    logic        exp_irq;
    wr(A_PRESET, 32'd4);
    wr(A_CTRL, 32'b1001);
    for (int k = 1; k <= 9; k++) begin
      step();
      if (k >= 2) begin
        rd(A_COUNT, v);
        checks++;
        if (v !== ((k <= 6) ? 32'(6 - k) : 32'd0)) begin
          errors++;
          $display("FAIL oneshot_count k=%0d got=%0d exp=%0d", k, v, ((k <= 6) ? 6 - k : 0));
        end
      end
      exp_irq = (k >= 7) ? IRQ_ON : 1'b0;
      checks++;
      if (bus_if.irq !== exp_irq) begin
        errors++;
        $display("FAIL oneshot_irq k=%0d got=%b exp=%b", k, bus_if.irq, exp_irq);
      end
    end
    rd(A_CTRL, v);
    checks++;
    if (v !== (IRQ_ON ? 32'h8 : 32'h0)) begin
      errors++;
      $display("FAIL oneshot_en_cleared got=%h exp=%h", v, (IRQ_ON ? 32'h8 : 32'h0));
    end
    wr(A_CTRL, 32'd0);
    checks++;
    if (bus_if.irq !== 1'b0) begin
      errors++;
      $display("FAIL oneshot_irq_clear got=%b exp=0", bus_if.irq);
    end
  endtask

  task automatic test_autoreload();
    logic [31:0] v;
    logic [31:0] exp_cnt;
    logic        exp_irq;
    int          p;
    wr(A_PRESET, 32'd2);
    wr(A_CTRL, 32'b1011);
    for (int k = 1; k <= 22; k++) begin
      step();
      if (k >= 2) begin
        p = (k - 2) % 5;
        exp_cnt = (p == 0) ? 32'd2 : ((p == 1) ? 32'd1 : 32'd0);
        rd(A_COUNT, v);
        checks++;
        if (v !== exp_cnt) begin
          errors++;
          $display("FAIL auto_count k=%0d got=%0d exp=%0d", k, v, exp_cnt);
        end
      end
      exp_irq = ((k >= 6) && (((k - 6) % 5) == 0)) ? IRQ_ON : 1'b0;
      checks++;
      if (bus_if.irq !== exp_irq) begin
        errors++;
        $display("FAIL auto_irq k=%0d got=%b exp=%b", k, bus_if.irq, exp_irq);
      end
    end
    wr(A_CTRL, 32'd0);
    step();
    step();
  endtask

  task automatic test_preset_zero();
    logic [31:0] v;
    logic        exp_irq;
    wr(A_PRESET, 32'd0);
    wr(A_CTRL, 32'b1001);
    for (int k = 1; k <= 4; k++) begin
      step();
      exp_irq = (k >= 3) ? IRQ_ON : 1'b0;
      checks++;
      if (bus_if.irq !== exp_irq) begin
        errors++;
        $display("FAIL pz_irq k=%0d got=%b exp=%b", k, bus_if.irq, exp_irq);
      end
      if (k == 3) begin
        rd(A_CTRL, v);
        checks++;
        if (v !== (IRQ_ON ? 32'h8 : 32'h0)) begin
          errors++;
          $display("FAIL pz_en_cleared got=%h exp=%h", v, (IRQ_ON ? 32'h8 : 32'h0));
        end
      end
    end
    wr(A_CTRL, 32'd0);
  endtask

  task automatic test_pause();
    logic [31:0] v;
    wr(A_PRESET, 32'd10);
    wr(A_CTRL, 32'd1);
    for (int k = 1; k <= 8; k++) step();
    rd(A_COUNT, v);
    checks++;
    if (v !== 32'd4) begin
      errors++;
      $display("FAIL pause_pre got=%0d exp=4", v);
    end
    wr(A_CTRL, 32'd0);
    for (int k = 0; k <= 10; k++) begin
      rd(A_COUNT, v);
      checks++;
      if (v !== 32'd3) begin
        errors++;
        $display("FAIL pause_hold k=%0d got=%0d exp=3", k, v);
      end
      step();
    end
    wr(A_PRESET, 32'd7);
    wr(A_CTRL, 32'd1);
    step();
    rd(A_COUNT, v);
    checks++;
    if (v !== 32'd3) begin
      errors++;
      $display("FAIL resume_load got=%0d exp=3", v);
    end
    step();
    rd(A_COUNT, v);
    checks++;
    if (v !== 32'd7) begin
      errors++;
      $display("FAIL resume_reload got=%0d exp=7", v);
    end
    wr(A_CTRL, 32'd0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    wr(A_PRESET, 32'd1);
    wr(A_CTRL, 32'b1001);
    for (int k = 1; k <= 3; k++) step();
    rd(A_COUNT, v);
    checks++;
    if (v !== 32'd0) begin
      errors++;
      $display("FAIL same_edge_pre got=%0d exp=0", v);
    end
    // CTRL write lands on the INT-entry edge
    wr(A_CTRL, 32'b1001);
    rd(A_CTRL, v);
    checks++;
    if (v !== (IRQ_ON ? 32'h9 : 32'h1)) begin
      errors++;
      $display("FAIL same_edge_en got=%h exp=%h", v, (IRQ_ON ? 32'h9 : 32'h1));
    end
    checks++;
    if (bus_if.irq !== IRQ_ON) begin
      errors++;
      $display("FAIL same_edge_pending got=%b exp=%b", bus_if.irq, IRQ_ON);
    end
    for (int k = 5; k <= 7; k++) step();
    rd(A_COUNT, v);
    checks++;
    if (v !== 32'd1) begin
      errors++;
      $display("FAIL same_edge_reload got=%0d exp=1", v);
    end
    checks++;
    if (bus_if.irq !== IRQ_ON) begin
      errors++;
      $display("FAIL same_edge_irq_held got=%b exp=%b", bus_if.irq, IRQ_ON);
    end
    step();
    step();
    rd(A_CTRL, v);
    checks++;
    if (v !== (IRQ_ON ? 32'h8 : 32'h0)) begin
      errors++;
      $display("FAIL same_edge_second_expiry got=%h exp=%h", v, (IRQ_ON ? 32'h8 : 32'h0));
    end
    wr(A_CTRL, 32'd0);
  endtask

  initial begin
    errors       = 0;
    checks       = 0;
    rst_n        = 1'b0;
    bus_if.we    = 1'b0;
    bus_if.addr  = 2'd0;
    bus_if.wdata = 32'd0;
    test_reset();
    test_regs();
    test_oneshot();
    test_autoreload();
    test_preset_zero();
    test_pause();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
